// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_CH prescaled compare timers with per-channel irq
//   clk            system clock
//   reset          asynchronous active-low reset
//   data_bus_data  shared 32-bit data bus, driven only on a decoded read
//   data_bus_addr  byte address
//   data_bus_mode  00 idle, 01 read, 10 write, 11 idle
//   irq            per-channel level interrupt (MATCH & IRQ_EN)
module timer_bank #(
  parameter logic [31:0] BASE_ADDR         = 32'h4040,
  parameter int          NUM_CH            = 2,
  parameter logic [31:0] DEFAULT_PRESCALER = 32'd16499,
  parameter logic [31:0] DEFAULT_COMPARE   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  inout  logic [31:0]       data_bus_data,
  input  logic [31:0]       data_bus_addr,
  input  logic [1:0]        data_bus_mode,
  output logic [NUM_CH-1:0] irq
);
  localparam logic [31:0] SPAN = 32'(NUM_CH) << 5;
  logic [31:0] rel;
  logic        hit;
  logic        wr_en;
  logic [2:0]  sel;
  logic [4:0]  off;
  logic [31:0] rd_data;
  logic [31:0] ch_rd [NUM_CH];
  assign rel   = data_bus_addr - BASE_ADDR;
  assign hit   = data_bus_addr >= BASE_ADDR && rel < SPAN && data_bus_addr[1:0] == 2'b00;
  assign wr_en = hit && data_bus_mode == 2'b10;
  assign sel   = rel[7:5];
  assign off   = rel[4:0];
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == 3'(i)) rd_data = ch_rd[i];
  end
  assign data_bus_data = (hit && data_bus_mode == 2'b01) ? rd_data : 'z;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0]  ctrl;
    logic [31:0] presc;
    logic [31:0] compare;
    logic [31:0] count;
    logic [31:0] pcnt;
    logic        match;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_presc;
    logic        wr_cmp;
    logic        wr_cnt;
    logic        wr_stat;
    logic        tick;
    logic        hit_cmp;
    logic        en_rise;
    assign wr       = wr_en && sel == 3'(c);
    assign wr_ctrl  = wr && off == 5'h00;
    assign wr_presc = wr && off == 5'h04;
    assign wr_cmp   = wr && off == 5'h08;
    assign wr_cnt   = wr && off == 5'h0C;
    assign wr_stat  = wr && off == 5'h10;
    assign tick     = ctrl[0] && pcnt >= presc;
    // a software COUNT write overrides this cycle's tick, so no match is evaluated
    assign hit_cmp  = tick && !wr_cnt && count >= compare;
    assign en_rise  = wr_ctrl && data_bus_data[0] && !ctrl[0];
    assign irq[c]   = match && ctrl[2];
    assign ch_rd[c] = off == 5'h00 ? {29'd0, ctrl} :
                      off == 5'h04 ? presc :
                      off == 5'h08 ? compare :
                      off == 5'h0C ? count :
                      off == 5'h10 ? {31'd0, match} : 32'd0;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctrl    <= '0;
        presc   <= DEFAULT_PRESCALER;
        compare <= DEFAULT_COMPARE;
        count   <= '0;
        pcnt    <= '0;
        match   <= 1'b0;
      end else begin
        ctrl    <= wr_ctrl ? data_bus_data[2:0] : (hit_cmp && !ctrl[1]) ? {ctrl[2:1], 1'b0} : ctrl;
        presc   <= wr_presc ? data_bus_data : presc;
        compare <= wr_cmp ? data_bus_data : compare;
        count   <= wr_cnt ? data_bus_data : hit_cmp ? 32'd0 : tick ? count + 32'd1 : count;
        pcnt    <= (wr_presc || en_rise || tick) ? 32'd0 : ctrl[0] ? pcnt + 32'd1 : pcnt;
        match   <= hit_cmp || (match && !(wr_stat && data_bus_data[0]));
      end
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed self-checking bench for timer_bank
module tb_timer_bank;
  localparam logic [31:0] B0 = 32'h4040;
  localparam logic [31:0] B1 = 32'h4060;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] tb_drv = '0;
  logic        tb_oe = 1'b0;
  logic [1:0]  irq;
  wire  [31:0] bus;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] v;
  assign bus = tb_oe ? tb_drv : 32'bz;
  timer_bank dut (
    .clk(clk),
    .reset(reset),
    .data_bus_data(bus),
    .data_bus_addr(addr),
    .data_bus_mode(mode)
    ,.irq(irq)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    tb_drv = d;
    tb_oe = 1'b1;
    mode = 2'b10;
    @(posedge clk);
    #1;
    mode = 2'b00;
    tb_oe = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    addr = a;
    mode = 2'b01;
    #1;
    r = bus;
    mode = 2'b00;
  endtask
  task automatic test_reset;
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL rst_irq got %h exp 0", irq); end
    rd(B0 + 32'h04, v);
    checks++; if (v !== 32'd16499) begin errors++; $display("FAIL rst_presc got %h exp %h", v, 32'd16499); end
    rd(B0 + 32'h08, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare got %h exp ffffffff", v); end
    rd(B0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", v); end
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", v); end
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_status got %h exp 0", v); end
    step;
    rd(B0 + 32'h44, v);
    checks++; if (v !== 32'bz && v !== 32'd0) begin errors++; $display("FAIL miss_44 got %h exp z", v); end
    rd(B0 + 32'h06, v);
    checks++; if (v !== 32'bz && v !== 32'd0) begin errors++; $display("FAIL misaligned got %h exp z", v); end
    rd(B1 + 32'h14, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL unlisted got %h exp 0", v); end
  endtask
  task automatic test_periodic;
    wr(B0 + 32'h04, 32'd3);
    wr(B0 + 32'h08, 32'd4);
    wr(B0 + 32'h14, 32'hFFFF_FFFF);
    wr(B0, 32'h7);
    repeat (4) step;
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL per_count4 got %h exp 1", v); end
    rd(B0 + 32'h40, v);
    checks++; if (v !== 32'bz && v !== 32'd0) begin errors++; $display("FAIL miss_40 got %h exp z", v); end
    repeat (15) step;
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL per_stat19 got %h exp 0", v); end
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL per_irq19 got %b exp 0", irq[0]); end
    step;
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL per_stat20 got %h exp 1", v); end
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL per_irq20 got %b exp 1", irq[0]); end
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL per_count20 got %h exp 0", v); end
    wr(B0 + 32'h10, 32'd1);
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL w1c_stat got %h exp 0", v); end
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq[0]); end
    repeat (18) step;
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL per_stat39 got %h exp 0", v); end
    step;
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL per_stat40 got %h exp 1", v); end
    repeat (19) step;
    wr(B0 + 32'h10, 32'd1);
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL w1c_collide got %h exp 1", v); end
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL w1c_collide_irq got %b exp 1", irq[0]); end
    wr(B0, 32'h0);
  endtask
  task automatic test_oneshot;
    rd(B1 + 32'h04, v);
    checks++; if (v !== 32'd16499) begin errors++; $display("FAIL ch1_isolated got %h exp %h", v, 32'd16499); end
    wr(B1 + 32'h04, 32'd0);
    wr(B1 + 32'h08, 32'd2);
    wr(B1, 32'h1);
    repeat (2) step;
    rd(B1 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL os_stat2 got %h exp 0", v); end
    rd(B1 + 32'h0C, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL os_count2 got %h exp 2", v); end
    step;
    rd(B1 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL os_stat3 got %h exp 1", v); end
    rd(B1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL os_ctrl3 got %h exp 0", v); end
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL os_irq got %b exp 0", irq[1]); end
    repeat (3) step;
    rd(B1 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL os_count_hold got %h exp 0", v); end
    wr(B1 + 32'h10, 32'd1);
    wr(B1, 32'h1);
    repeat (2) step;
    wr(B1, 32'h3);
    rd(B1, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL ctrl_collide got %h exp 3", v); end
    rd(B1 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL ctrl_collide_stat got %h exp 1", v); end
    wr(B1, 32'h0);
    rd(B0 + 32'h04, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL ch0_isolated got %h exp 3", v); end
  endtask
  task automatic test_count_collision;
    wr(B0 + 32'h10, 32'd1);
    wr(B0, 32'h7);
    repeat (3) step;
    wr(B0 + 32'h0C, 32'h10);
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL cnt_wr got %h exp 10", v); end
    repeat (3) step;
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL cnt_hold got %h exp 10", v); end
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL cnt_stat_pre got %h exp 0", v); end
    step;
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL cnt_match got %h exp 1", v); end
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL cnt_wrap got %h exp 0", v); end
  endtask
  task automatic test_reset_mid;
    repeat (12) step;
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL mid_count got %h exp 3", v); end
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL mid_irq got %b exp 1", irq[0]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL async_irq got %h exp 0", irq); end
    rd(B0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL async_ctrl got %h exp 0", v); end
    rd(B0 + 32'h04, v);
    checks++; if (v !== 32'd16499) begin errors++; $display("FAIL async_presc got %h exp %h", v, 32'd16499); end
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL async_count got %h exp 0", v); end
    rd(B0 + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL async_stat got %h exp 0", v); end
    rd(B1 + 32'h08, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_ch1_cmp got %h exp ffffffff", v); end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) step;
    rd(B0 + 32'h0C, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL no_resume got %h exp 0", v); end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step;
    test_reset;
    test_periodic;
    test_oneshot;
    test_count_collision;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
